// File: rtl/mem_access_ctrl.sv
// MEM-stage controller for a multi-cycle single-port data SRAM: holds ready low for WAIT_STATES+1 cycles per access.
// Defining MEM_ALIGN_CHECK_EN faults misaligned/out-of-window requests (err in DONE, no strobes).
module mem_access_ctrl #(
  parameter int          WAIT_STATES = 4,
  parameter int          ADDR_W      = 6,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_W_EN,
  input  logic              MEM_R_EN,
  input  logic [31:0]       ALU_Res,
  input  logic [31:0]       Val_Rm,
  output logic              ready,
  output logic [31:0]       rd_data,
  output logic              err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              sram_we,
  output logic              sram_oe,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_fault;
  logic              r_we;
  logic              r_oe;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;

  logic              w_req;
  logic              w_fault;
  logic [31:0]       w_offset;
  logic              w_unused;

  assign w_req    = MEM_W_EN | MEM_R_EN;
  assign w_offset = ALU_Res - BASE_ADDR;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_fault  = (ALU_Res[1:0] != 2'b00) | (ALU_Res < BASE_ADDR) |
                    ((w_offset >> (ADDR_W + 2)) != 32'd0);
  assign err      = r_err;
  assign w_unused = ^w_offset[1:0];
`else
  assign w_fault  = 1'b0;
  assign err      = 1'b0;
  assign w_unused = ^{w_offset[31:ADDR_W+2], w_offset[1:0], r_err};
`endif

  // Only the IDLE term looks at the enables; the freeze starts in the request cycle itself.
  assign ready      = rst | (r_state == S_DONE) | ((r_state == S_IDLE) & ~w_req);
  assign rd_data    = r_rdata;
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;
  assign sram_we    = r_we;
  assign sram_oe    = r_oe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_fault <= 1'b0;
      r_we    <= 1'b0;
      r_oe    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr  <= w_offset[ADDR_W+1:2];
            r_wdata <= Val_Rm;
            r_fault <= w_fault;
            r_cnt   <= CNT_INIT;
            // A write wins when both enables are high.
            r_we    <= MEM_W_EN & ~w_fault;
            r_oe    <= ~MEM_W_EN & ~w_fault;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_we    <= 1'b0;
            r_oe    <= 1'b0;
            r_err   <= r_fault;
            if (r_oe) begin
              r_rdata <= sram_rdata;
            end
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected accesses queued at issue, compared against per-DONE observations.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  localparam int WS = 4;
  localparam int AW = 6;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   rd;
    logic [31:0]   wdata;
    logic          err;
    int            we;
    int            oe;
    int            frz;
    int            cyc;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_w_en;
  logic          mem_r_en;
  logic [31:0]   alu_res;
  logic [31:0]   val_rm;
  logic          ready;
  logic [31:0]   rd_data;
  logic          err;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic          sram_we;
  logic          sram_oe;
  logic [31:0]   sram_rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mem_access_ctrl #(.WAIT_STATES(WS), .ADDR_W(AW), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .MEM_W_EN(mem_w_en), .MEM_R_EN(mem_r_en),
    .ALU_Res(alu_res), .Val_Rm(val_rm), .ready(ready), .rd_data(rd_data), .err(err),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we), .sram_oe(sram_oe),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM behavioural model
  logic [31:0] sram_mem [64];
  assign sram_rdata = sram_oe ? sram_mem[sram_addr] : 32'h0;
  always @(posedge clk) if (sram_we) sram_mem[sram_addr] <= sram_wdata;

  // Reference model state
  logic [31:0] model_mem [64];
  logic [31:0] model_rd;

  rec_t exp_q[$];
  rec_t obs_q[$];

  // Monitor: one observation per DONE cycle (ready rising after a freeze).
  int   m_we, m_oe, m_frz;
  logic prev_rdy;
  rec_t mon_r;
  always @(negedge clk) begin
    if (rst) begin
      m_we = 0; m_oe = 0; m_frz = 0; prev_rdy = 1'b1;
    end else begin
      if (sram_we) m_we++;
      if (sram_oe) m_oe++;
      if (!ready) m_frz++;
      if (ready && !prev_rdy) begin
        mon_r.addr = sram_addr; mon_r.rd = rd_data; mon_r.wdata = sram_wdata;
        mon_r.err = err; mon_r.we = m_we; mon_r.oe = m_oe; mon_r.frz = m_frz; mon_r.cyc = cyc;
        obs_q.push_back(mon_r);
        m_we = 0; m_oe = 0; m_frz = 0;
      end
      prev_rdy = ready;
    end
  end

  task automatic push_exp(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    rec_t          e;
    logic          flt;
    logic [AW-1:0] w;
    w = AW'((a - 32'd1024) >> 2);
`ifdef MEM_ALIGN_CHECK_EN
    flt = (a[1:0] != 2'b00) || (a < 32'd1024) || (a >= 32'd1280);
`else
    flt = 1'b0;
`endif
    if (we && !flt) model_mem[w] = d;
    else if (re && !flt) model_rd = model_mem[w];
    e.addr = w; e.wdata = d; e.err = flt; e.rd = model_rd;
    e.we = (we && !flt) ? WS : 0;
    e.oe = (!we && re && !flt) ? WS : 0;
    e.frz = WS + 1; e.cyc = 0;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    push_exp(we, re, a, d);
    @(posedge clk); #1;
    mem_w_en = we; mem_r_en = re; alu_res = a; val_rm = d;
    @(posedge clk); #1;
    mem_w_en = 1'b0; mem_r_en = 1'b0;
  endtask

  task automatic wait_obs(input int n, output logic ok);
    int t;
    t = 0;
    while (obs_q.size() < n && t < 80) begin
      @(negedge clk);
      t++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_w_en = 1'b1; mem_r_en = 1'b0; alu_res = 32'd1032; val_rm = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready_en: got %b want 1", ready); end
    mem_w_en = 1'b0; #1;
    total++; if (sram_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", sram_we); end
    total++; if (sram_oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", sram_oe); end
    total++; if (sram_addr !== 6'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", sram_addr); end
    total++; if (sram_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata: got %h want 0", sram_wdata); end
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    @(negedge clk);
    rst = 1'b0; model_rd = 32'd0;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL idle_ready: got %b want 1", ready); end
  endtask

  task automatic test_write_read();
    rec_t e, o;
    logic ok;
    issue(1'b1, 1'b0, 32'd1032, 32'hDEAD_BEEF); wait_obs(1, ok);
    issue(1'b0, 1'b1, 32'd1032, 32'h0000_0000); wait_obs(2, ok);
    total++; if (!ok) begin bad++; $display("FAIL wr_rd timeout: got %0d dones want 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o.addr !== e.addr) begin bad++; $display("FAIL wr_rd addr: got %0d want %0d", o.addr, e.addr); end
      total++; if (o.rd !== e.rd) begin bad++; $display("FAIL wr_rd rd_data: got %h want %h", o.rd, e.rd); end
      total++; if (o.wdata !== e.wdata) begin bad++; $display("FAIL wr_rd wdata: got %h want %h", o.wdata, e.wdata); end
      total++; if (o.err !== e.err) begin bad++; $display("FAIL wr_rd err: got %b want %b", o.err, e.err); end
      total++; if (o.we !== e.we) begin bad++; $display("FAIL wr_rd we_cycles: got %0d want %0d", o.we, e.we); end
      total++; if (o.oe !== e.oe) begin bad++; $display("FAIL wr_rd oe_cycles: got %0d want %0d", o.oe, e.oe); end
      total++; if (o.frz !== e.frz) begin bad++; $display("FAIL wr_rd freeze: got %0d want %0d", o.frz, e.frz); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_both_en();
    rec_t e, o;
    logic ok;
    issue(1'b1, 1'b1, 32'd1028, 32'h1234_5678); wait_obs(1, ok);
    issue(1'b0, 1'b1, 32'd1028, 32'h0000_0000); wait_obs(2, ok);
    total++; if (!ok) begin bad++; $display("FAIL both_en timeout: got %0d dones want 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o.addr !== e.addr) begin bad++; $display("FAIL both_en addr: got %0d want %0d", o.addr, e.addr); end
      total++; if (o.rd !== e.rd) begin bad++; $display("FAIL both_en rd_data: got %h want %h", o.rd, e.rd); end
      total++; if (o.we !== e.we) begin bad++; $display("FAIL both_en we_cycles: got %0d want %0d", o.we, e.we); end
      total++; if (o.oe !== e.oe) begin bad++; $display("FAIL both_en oe_cycles: got %0d want %0d", o.oe, e.oe); end
      total++; if (o.frz !== e.frz) begin bad++; $display("FAIL both_en freeze: got %0d want %0d", o.frz, e.frz); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    rec_t e, o;
    logic ok;
    @(posedge clk); #1;
    mem_w_en = 1'b1; alu_res = 32'd1040; val_rm = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_w_en = 1'b0;
    @(posedge clk); #2;
    total++; if (sram_we !== 1'b1) begin bad++; $display("FAIL rst_mid we_before: got %b want 1", sram_we); end
    rst = 1'b1; #1;
    total++; if (sram_we !== 1'b0) begin bad++; $display("FAIL rst_mid we_async: got %b want 0", sram_we); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_mid ready: got %b want 1", ready); end
    total++; if (sram_addr !== 6'd0) begin bad++; $display("FAIL rst_mid addr: got %0d want 0", sram_addr); end
    repeat (2) @(negedge clk);
    rst = 1'b0; model_rd = 32'd0;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_mid idle_ready: got %b want 1", ready); end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rst_mid spurious_done: got %0d want 0", obs_q.size()); end
    issue(1'b0, 1'b1, 32'd1032, 32'h0000_0000); wait_obs(1, ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_mid timeout: got %0d dones want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o.rd !== e.rd) begin bad++; $display("FAIL rst_mid rd_data: got %h want %h", o.rd, e.rd); end
      total++; if (o.frz !== e.frz) begin bad++; $display("FAIL rst_mid freeze: got %0d want %0d", o.frz, e.frz); end
      total++; if (o.oe !== e.oe) begin bad++; $display("FAIL rst_mid oe_cycles: got %0d want %0d", o.oe, e.oe); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    logic ok;
    int   dcyc [2];
    int   k;
    issue(1'b1, 1'b0, 32'd1024, 32'hA5A5_0000); wait_obs(1, ok);
    issue(1'b1, 1'b0, 32'd1276, 32'h5A5A_003F); wait_obs(2, ok);
    exp_q.delete(); obs_q.delete();
    push_exp(1'b0, 1'b1, 32'd1024, 32'd0);
    push_exp(1'b0, 1'b1, 32'd1276, 32'd0);
    @(posedge clk); #1;
    mem_r_en = 1'b1; alu_res = 32'd1024; val_rm = 32'd0;
    @(posedge clk); #1;
    alu_res = 32'd1276;
    repeat (WS + 2) @(posedge clk);
    #1 mem_r_en = 1'b0;
    wait_obs(2, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b timeout: got %0d dones want 2", obs_q.size()); end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      dcyc[k] = o.cyc; k++;
      total++; if (o.addr !== e.addr) begin bad++; $display("FAIL b2b addr: got %0d want %0d", o.addr, e.addr); end
      total++; if (o.rd !== e.rd) begin bad++; $display("FAIL b2b rd_data: got %h want %h", o.rd, e.rd); end
      total++; if (o.oe !== e.oe) begin bad++; $display("FAIL b2b oe_cycles: got %0d want %0d", o.oe, e.oe); end
      total++; if (o.frz !== e.frz) begin bad++; $display("FAIL b2b freeze: got %0d want %0d", o.frz, e.frz); end
    end
    if (k == 2) begin
      total++; if (dcyc[1] - dcyc[0] != WS + 2) begin bad++; $display("FAIL b2b done_spacing: got %0d want %0d", dcyc[1] - dcyc[0], WS + 2); end
    end
    repeat (12) @(negedge clk);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL b2b extra_done: got %0d want 0", obs_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_range();
    rec_t e, o;
    logic ok;
    issue(1'b1, 1'b0, 32'd1280, 32'h0BAD_F00D); wait_obs(1, ok);
    issue(1'b0, 1'b1, 32'd1276, 32'h0000_0000); wait_obs(2, ok);
    issue(1'b0, 1'b1, 32'd1025, 32'h0000_0000); wait_obs(3, ok);
    total++; if (!ok) begin bad++; $display("FAIL range timeout: got %0d dones want 3", obs_q.size()); end
    @(negedge clk);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL range err_after_done: got %b want 0", err); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o.addr !== e.addr) begin bad++; $display("FAIL range addr: got %0d want %0d", o.addr, e.addr); end
      total++; if (o.rd !== e.rd) begin bad++; $display("FAIL range rd_data: got %h want %h", o.rd, e.rd); end
      total++; if (o.err !== e.err) begin bad++; $display("FAIL range err: got %b want %b", o.err, e.err); end
      total++; if (o.we !== e.we) begin bad++; $display("FAIL range we_cycles: got %0d want %0d", o.we, e.we); end
      total++; if (o.oe !== e.oe) begin bad++; $display("FAIL range oe_cycles: got %0d want %0d", o.oe, e.oe); end
      total++; if (o.frz !== e.frz) begin bad++; $display("FAIL range freeze: got %0d want %0d", o.frz, e.frz); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    rst = 1'b1; mem_w_en = 1'b0; mem_r_en = 1'b0; alu_res = 32'd0; val_rm = 32'd0;
    model_rd = 32'd0;
    test_reset();
    test_write_read();
    test_both_en();
    test_reset_mid();
    test_back_to_back();
    test_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
